// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
//   Shared constants and types for the common-data-bus arbiter slice.
//   ROB_SIZE_WIDTH : width of a reorder-buffer id
//   CDB_FIFO_DEPTH : entries buffered per result source
//   CDB_DATA_WIDTH : width of a broadcast result value
//   cdb_src_e      : identifies which producer owns a grant
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int ROB_SIZE_WIDTH = 5;
    localparam int CDB_FIFO_DEPTH = 4;
    localparam int CDB_DATA_WIDTH = 32;

    // Encoding doubles as the index into the per-source arrays in the arbiter.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
//   Bundles the two producer result ports, their stall back-pressure and the
//   broadcast CDB outputs.
//   master : producer / consumer side (drives results, sees stalls and CDB)
//   slave  : arbiter side (takes results, drives stalls, CDB and ovf_err)
// -----------------------------------------------------------------------------
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_W  = ROB_SIZE_WIDTH,
    parameter int DATA_W = CDB_DATA_WIDTH
);

    logic              alu_valid;
    logic [ROB_W-1:0]  alu_rob_id;
    logic [DATA_W-1:0] alu_value;
    logic              alu_stall;

    logic              lsb_valid;
    logic [ROB_W-1:0]  lsb_rob_id;
    logic [DATA_W-1:0] lsb_value;
    logic              lsb_stall;

    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_rob_id;
    logic [DATA_W-1:0] cdb_value;
    logic              ovf_err;

    modport master (
        output alu_valid, alu_rob_id, alu_value,
        output lsb_valid, lsb_rob_id, lsb_value,
        input  alu_stall, lsb_stall,
        input  cdb_valid, cdb_rob_id, cdb_value, ovf_err
    );

    modport slave (
        input  alu_valid, alu_rob_id, alu_value,
        input  lsb_valid, lsb_rob_id, lsb_value,
        output alu_stall, lsb_stall,
        output cdb_valid, cdb_rob_id, cdb_value, ovf_err
    );

endinterface

// File: rtl/cdb_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fifo
//   Small result FIFO with a combinationally visible head entry so the
//   arbiter can grant a result the cycle after it was written.
//   clk, rst(active-low, async) : clocking / reset
//   en    : global ready; 0 freezes pointers, count and storage
//   flush : empty the FIFO (only while en)
//   push  : write din (dropped when full)
//   pop   : retire the head entry (ignored when empty)
//   head  : current head entry
//   full, empty, count : occupancy
// -----------------------------------------------------------------------------
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter  int DEPTH = CDB_FIFO_DEPTH,
    parameter  int WIDTH = ROB_SIZE_WIDTH + CDB_DATA_WIDTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

    // Fullness is judged before any same-edge pop, so a push into a full
    // FIFO is dropped even if the head leaves at that edge.
    assign do_push = en && !flush && push && !full;
    assign do_pop  = en && !flush && pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (en) begin
            if (flush) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                // DEPTH is a power of two, so pointers wrap naturally.
                if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                case ({do_push, do_pop})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // Storage carries no reset; only entries below count are ever read out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares the common data bus between the ALU and LSB result ports. Each
//   source is buffered in a cdb_fifo; one head is granted per cycle,
//   round-robin, into registered cdb_* outputs.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   rdy       : global ready; 0 freezes all state and drops inputs
//   rob_clear : misprediction flush (effective only with rdy)
//   bus       : producer results, stalls, CDB broadcast and ovf_err
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH  = CDB_FIFO_DEPTH,
    parameter int ROB_W  = ROB_SIZE_WIDTH,
    parameter int DATA_W = CDB_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          rob_clear,
    cdb_arbiter_if.slave  bus
);

    localparam int ENT_W = ROB_W + DATA_W;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NSRC  = 2;

    // Per-source arrays are indexed by cdb_src_e: 0 = ALU, 1 = LSB.
    logic [NSRC-1:0]  src_valid;
    logic [NSRC-1:0]  src_full;
    logic [NSRC-1:0]  src_empty;
    logic [NSRC-1:0]  grant;
    logic [NSRC-1:0]  pop;
    logic [ENT_W-1:0] src_din   [NSRC];
    logic [ENT_W-1:0] src_head  [NSRC];
    logic [CNT_W-1:0] src_count [NSRC];

    cdb_src_e          last_grant_reg;
    logic              cdb_valid_reg;
    logic [ROB_W-1:0]  cdb_rob_id_reg;
    logic [DATA_W-1:0] cdb_value_reg;
    logic              ovf_err_reg;

    assign src_valid  = {bus.lsb_valid, bus.alu_valid};
    assign src_din[0] = {bus.alu_rob_id, bus.alu_value};
    assign src_din[1] = {bus.lsb_rob_id, bus.lsb_value};

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            cdb_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (ENT_W)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .en    (rdy),
                .flush (rob_clear),
                .push  (src_valid[gi]),
                .pop   (pop[gi]),
                .din   (src_din[gi]),
                .head  (src_head[gi]),
                .full  (src_full[gi]),
                .empty (src_empty[gi]),
                .count (src_count[gi])
            );

            assign pop[gi] = grant[gi] && !rob_clear;
        end
    endgenerate

    // A lone nonempty source always wins; on contention the source that
    // did not win last time goes first.
    always_comb begin
        grant    = '0;
        grant[0] = !src_empty[0] && (src_empty[1] || last_grant_reg == SRC_LSB);
        grant[1] = !src_empty[1] && (src_empty[0] || last_grant_reg == SRC_ALU);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_reg <= SRC_LSB;
            cdb_valid_reg  <= 1'b0;
            cdb_rob_id_reg <= '0;
            cdb_value_reg  <= '0;
            ovf_err_reg    <= 1'b0;
        end else if (rdy) begin
            if (rob_clear) begin
                cdb_valid_reg  <= 1'b0;
                last_grant_reg <= SRC_LSB;
            end else begin
                if (grant[0]) begin
                    cdb_valid_reg                    <= 1'b1;
                    {cdb_rob_id_reg, cdb_value_reg}  <= src_head[0];
                    last_grant_reg                   <= SRC_ALU;
                end else if (grant[1]) begin
                    cdb_valid_reg                    <= 1'b1;
                    {cdb_rob_id_reg, cdb_value_reg}  <= src_head[1];
                    last_grant_reg                   <= SRC_LSB;
                end else begin
                    cdb_valid_reg <= 1'b0;
                end
                // Sticky: a producer ignored its stall and lost a result.
                if (|(src_valid & src_full)) ovf_err_reg <= 1'b1;
            end
        end
    end

    // One slot of slack: the producer's issue decision is a cycle ahead of
    // its result arriving here.
    assign bus.alu_stall  = (src_count[0] >= CNT_W'(DEPTH - 1));
    assign bus.lsb_stall  = (src_count[1] >= CNT_W'(DEPTH - 1));
    assign bus.cdb_valid  = cdb_valid_reg;
    assign bus.cdb_rob_id = cdb_rob_id_reg;
    assign bus.cdb_value  = cdb_value_reg;
    assign bus.ovf_err    = ovf_err_reg;

endmodule
